// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared encodings for the sequential shift unit:
//   - shift operation codes (op port)
//   - shift-amount source codes (amt_sel port)
//   - control FSM state enum (2-bit encoding)
// -----------------------------------------------------------------------------
package shift_pkg;

  // Shift operations
  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  // Shift-amount sources
  localparam logic [1:0] AMT_INSTR = 2'b00;
  localparam logic [1:0] AMT_CONST = 2'b01;
  localparam logic [1:0] AMT_REG_A = 2'b10;
  localparam logic [1:0] AMT_REG_B = 2'b11;

  // Control FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } shift_state_t;

endpackage : shift_pkg

// File: rtl/shift_amt_sel.sv
// -----------------------------------------------------------------------------
// shift_amt_sel
// Combinational 4:1 shift-amount selector.
// Ports:
//   i_amt_sel    in  2        source select (AMT_INSTR/AMT_CONST/AMT_REG_A/AMT_REG_B)
//   i_instr      in  DATA_W   instruction word, amount taken from [SHAMT_LSB +: SHAMT_W]
//   i_amt_reg_a  in  DATA_W   register operand A, low SHAMT_W bits used
//   i_amt_reg_b  in  DATA_W   register operand B, low SHAMT_W bits used
//   o_amt        out SHAMT_W  selected shift amount
// -----------------------------------------------------------------------------
module shift_amt_sel
  import shift_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int SHAMT_W   = 5,
  parameter int SHAMT_LSB = 6,
  parameter int CONST_AMT = 16
) (
  input  logic [1:0]         i_amt_sel,
  input  logic [DATA_W-1:0]  i_instr,
  input  logic [DATA_W-1:0]  i_amt_reg_a,
  input  logic [DATA_W-1:0]  i_amt_reg_b,
  output logic [SHAMT_W-1:0] o_amt
);

  // Only a slice of each wide input matters; fold the rest away explicitly.
  logic w_unused_bits;
  assign w_unused_bits = ^{i_instr, i_amt_reg_a, i_amt_reg_b};

  always_comb begin
    o_amt = '0;
    case (i_amt_sel)
      AMT_INSTR: o_amt = i_instr[SHAMT_LSB +: SHAMT_W];
      AMT_CONST: o_amt = SHAMT_W'(CONST_AMT);
      AMT_REG_A: o_amt = i_amt_reg_a[SHAMT_W-1:0];
      AMT_REG_B: o_amt = i_amt_reg_b[SHAMT_W-1:0];
      default:   o_amt = '0;
    endcase
  end

endmodule : shift_amt_sel

// File: rtl/shift_unit_seq.sv
// -----------------------------------------------------------------------------
// shift_unit_seq
// Multi-cycle shift unit: selects a shift amount from one of four sources,
// then shifts the captured operand by up to STEP bits per cycle. Handshake is
// start / busy / done; the result is held from DONE until the next accepted
// start.
//
// Configuration macro: SHIFT_UNIT_ROTATE_EN
//   defined   -> op=11 rotates right, multi-cycle like the other shifts
//   undefined -> op=11 is a no-op: result=src_data, straight to DONE
//
// Ports:
//   clk        in  1       rising-edge clock
//   reset      in  1       synchronous, active-low
//   start      in  1       request, sampled only in IDLE/DONE
//   op         in  2       SH_SLL / SH_SRL / SH_SRA / SH_ROR
//   amt_sel    in  2       amount source select
//   src_data   in  DATA_W  value to shift
//   instr      in  DATA_W  instruction word
//   amt_reg_a  in  DATA_W  register operand A
//   amt_reg_b  in  DATA_W  register operand B
//   busy       out 1       high in SHIFT
//   done       out 1       high for the single DONE cycle
//   result     out DATA_W  shifted value register
// -----------------------------------------------------------------------------
module shift_unit_seq
  import shift_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int SHAMT_LSB = 6,
  parameter int CONST_AMT = 16,
  parameter int STEP      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [1:0]        amt_sel,
  input  logic [DATA_W-1:0] src_data,
  input  logic [DATA_W-1:0] instr,
  input  logic [DATA_W-1:0] amt_reg_a,
  input  logic [DATA_W-1:0] amt_reg_b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int SHAMT_W = $clog2(DATA_W);
  // STEP may equal DATA_W, which needs one bit more than SHAMT_W.
  localparam logic [SHAMT_W:0] STEP_EXT = (SHAMT_W+1)'(STEP);

  shift_state_t       r_state;
  shift_state_t       w_state_next;
  logic [DATA_W-1:0]  r_result;
  logic [1:0]         r_op;
  logic [SHAMT_W-1:0] r_rem;

  logic [SHAMT_W-1:0] w_amt;
  logic [SHAMT_W-1:0] w_k;
  logic [SHAMT_W-1:0] w_rem_after;
  logic [DATA_W-1:0]  w_step_result;
  logic               w_op_noop;
  logic               w_direct_done;
  logic               w_accept;

  // ---------------------------------------------------------------------------
  // Amount selection
  // ---------------------------------------------------------------------------
  shift_amt_sel #(
    .DATA_W    (DATA_W),
    .SHAMT_W   (SHAMT_W),
    .SHAMT_LSB (SHAMT_LSB),
    .CONST_AMT (CONST_AMT)
  ) u_amt_sel (
    .i_amt_sel   (amt_sel),
    .i_instr     (instr),
    .i_amt_reg_a (amt_reg_a),
    .i_amt_reg_b (amt_reg_b),
    .o_amt       (w_amt)
  );

`ifdef SHIFT_UNIT_ROTATE_EN
  assign w_op_noop = 1'b0;
`else
  // Without rotate support op=11 just passes src_data through.
  assign w_op_noop = (op == SH_ROR);
`endif

  assign w_accept      = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_direct_done = (w_amt == '0) || w_op_noop;

  // ---------------------------------------------------------------------------
  // Step shifter: k = min(rem, STEP) bits this cycle
  // ---------------------------------------------------------------------------
  assign w_k         = ({1'b0, r_rem} < STEP_EXT) ? r_rem : STEP_EXT[SHAMT_W-1:0];
  assign w_rem_after = r_rem - w_k;

`ifdef SHIFT_UNIT_ROTATE_EN
  logic [SHAMT_W:0] w_rot_left;
  assign w_rot_left = (SHAMT_W+1)'(DATA_W) - {1'b0, w_k};
`endif

  always_comb begin
    w_step_result = r_result;
    case (r_op)
      SH_SLL: w_step_result = r_result << w_k;
      SH_SRL: w_step_result = r_result >> w_k;
      // Sign fill comes from the current register value, step by step.
      SH_SRA: w_step_result = $signed(r_result) >>> w_k;
`ifdef SHIFT_UNIT_ROTATE_EN
      SH_ROR: w_step_result = (r_result >> w_k) | (r_result << w_rot_left);
`endif
      default: w_step_result = r_result;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_next = w_direct_done ? ST_DONE : ST_SHIFT;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (w_rem_after == '0) begin
          w_state_next = ST_DONE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = (r_state == ST_SHIFT);
    done = (r_state == ST_DONE);
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_result <= '0;
      r_op     <= SH_SLL;
      r_rem    <= '0;
    end else if (w_accept) begin
      r_result <= src_data;
      r_op     <= op;
      r_rem    <= w_op_noop ? '0 : w_amt;
    end else if (r_state == ST_SHIFT) begin
      r_result <= w_step_result;
      r_rem    <= w_rem_after;
    end
  end

  assign result = r_result;

endmodule : shift_unit_seq

// File: tb/tb_shift_unit_seq.sv
// -----------------------------------------------------------------------------
// tb_shift_unit_seq
// Directed plus randomized transactions against a behavioural reference model
// of the shift unit (whole-amount arithmetic shifts, closed-form latency).
// -----------------------------------------------------------------------------
module tb_shift_unit_seq;

  localparam int DATA_W    = 32;
  localparam int SHAMT_LSB = 6;
  localparam int CONST_AMT = 16;
  localparam int STEP      = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [1:0]        op;
  logic [1:0]        amt_sel;
  logic [DATA_W-1:0] src_data;
  logic [DATA_W-1:0] instr;
  logic [DATA_W-1:0] amt_reg_a;
  logic [DATA_W-1:0] amt_reg_b;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  shift_unit_seq #(
    .DATA_W    (DATA_W),
    .SHAMT_LSB (SHAMT_LSB),
    .CONST_AMT (CONST_AMT),
    .STEP      (STEP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .amt_sel   (amt_sel),
    .src_data  (src_data),
    .instr     (instr),
    .amt_reg_a (amt_reg_a),
    .amt_reg_b (amt_reg_b),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int model_amt(input logic [1:0] s, input logic [31:0] ins,
                                   input logic [31:0] a, input logic [31:0] b);
    case (s)
      2'd0:    return int'((ins >> SHAMT_LSB) % 32);
      2'd1:    return CONST_AMT;
      2'd2:    return int'(a % 32);
      default: return int'(b % 32);
    endcase
  endfunction

  function automatic bit model_noop(input logic [1:0] o);
`ifdef SHIFT_UNIT_ROTATE_EN
    return 1'b0;
`else
    return (o == 2'd3);
`endif
  endfunction

  function automatic logic [31:0] model_result(input logic [1:0] o, input int amt,
                                               input logic [31:0] src);
    case (o)
      2'd0: return src << amt;
      2'd1: return src >> amt;
      2'd2: return $signed(src) >>> amt;
      default: begin
        if (model_noop(o)) return src;
        return (src >> amt) | (src << (32 - amt));
      end
    endcase
  endfunction

  function automatic int model_cycles(input logic [1:0] o, input int amt);
    if (model_noop(o) || amt == 0) return 1;
    return 1 + (amt + STEP - 1) / STEP;
  endfunction

  // ---------------- one transaction ----------------
  task automatic run_op(input string tag, input logic [1:0] o, input logic [1:0] s,
                        input logic [31:0] src, input logic [31:0] ins,
                        input logic [31:0] a, input logic [31:0] b,
                        input bit poke_busy, input bit chk_drop);
    int amt, exp_cyc, cyc, busy_cyc;
    logic [31:0] exp_res;
    amt     = model_amt(s, ins, a, b);
    exp_res = model_result(o, amt, src);
    exp_cyc = model_cycles(o, amt);

    op = o; amt_sel = s; src_data = src; instr = ins; amt_reg_a = a; amt_reg_b = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Inputs must have been captured; disturb them.
    op = 2'($urandom); amt_sel = 2'($urandom); src_data = $urandom;
    instr = $urandom; amt_reg_a = $urandom; amt_reg_b = $urandom;
    cyc = 1;
    busy_cyc = 0;
    while (!done && cyc < 200) begin
      if (busy) busy_cyc++;
      if (poke_busy && busy && busy_cyc == 1) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    check_eq({tag, "_latency"}, cyc, exp_cyc);
    check_eq({tag, "_done"}, {31'd0, done}, 32'd1);
    check_eq({tag, "_result"}, result, exp_res);
    check_eq({tag, "_busycyc"}, busy_cyc, exp_cyc - 1);
    $display("txn %s op=%0d amt=%0d src=0x%08h result=0x%08h cycles=%0d", tag, o, amt, src, result, cyc);
    if (chk_drop) begin
      @(posedge clk); #1;
      check_eq({tag, "_done_drop"}, {31'd0, done}, 32'd0);
      check_eq({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
      check_eq({tag, "_hold"}, result, exp_res);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = '0; amt_sel = '0;
    src_data = '0; instr = '0; amt_reg_a = '0; amt_reg_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_result", result, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of an SLL by 20
    op = 2'd0; amt_sel = 2'd2; amt_reg_a = 32'd20; src_data = 32'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check_eq("midshift_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("rstmid_busy", {31'd0, busy}, 32'd0);
      check_eq("rstmid_done", {31'd0, done}, 32'd0);
      check_eq("rstmid_result", result, 32'd0);
    end
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check_eq("postrst_nodone", {31'd0, done | busy}, 32'd0);
    end
    $display("txn reset_mid_shift checked");

    // Directed cases
    run_op("sll_instr5", 2'd0, 2'd0, 32'h0000_0001, 32'd5 << 6, 32'h0, 32'h0, 1'b0, 1'b1);
    run_op("sra_rega31", 2'd2, 2'd2, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1);
    run_op("srl_const", 2'd1, 2'd1, 32'hABCD_1234, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    run_op("regb_zero", 2'd0, 2'd3, 32'h1234_5678, 32'h0, 32'h0, 32'h20, 1'b0, 1'b1);
    run_op("op11_amt4", 2'd3, 2'd2, 32'h0000_00F1, 32'h0, 32'd4, 32'h0, 1'b0, 1'b1);
    run_op("sll_max31", 2'd0, 2'd3, 32'h0000_0003, 32'h0, 32'h0, 32'd31, 1'b0, 1'b1);
    // Back-to-back: second start issued in the DONE cycle of the first
    run_op("b2b_first", 2'd1, 2'd2, 32'hF000_000F, 32'h0, 32'd7, 32'h0, 1'b0, 1'b0);
    run_op("b2b_second", 2'd2, 2'd3, 32'h8765_4321, 32'h0, 32'h0, 32'd13, 1'b0, 1'b1);

    // Randomized transactions
    for (int i = 0; i < 40; i++) begin
      run_op("rand", 2'($urandom), 2'($urandom), $urandom, $urandom, $urandom, $urandom,
             1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_shift_unit_seq

// File: doc/shift_unit_seq.md
Name: shift_unit_seq

Overview:
- Parametrised, multi-cycle shift unit for the multicycle CPU datapath; successor to the combinational shift-amount selector.
- Selects the shift amount from one of four sources, then shifts a DATA_W operand by up to STEP bits per cycle.
- Uses a start/busy/done handshake driven by the control unit FSM; the result is held until the next start.

Parameters:
- DATA_W, 32, operand/result width; power of two, ≥8
- SHAMT_W, $clog2(DATA_W), shift-amount width (derived localparam, not overridable)
- SHAMT_LSB, 6, LSB position of the shamt field in instr
- CONST_AMT, 16, constant amount for amt_sel=01 (LUI-style); must be < DATA_W
- STEP, 4, max bits shifted per cycle; power of two, 1..DATA_W

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low (reset==0 resets on the clk edge)
- start  in  1  request; sampled only when not busy
- op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR (see Optional Feature)
- amt_sel  in  2  00 instr[SHAMT_LSB+:SHAMT_W], 01 CONST_AMT, 10 amt_reg_a[SHAMT_W-1:0], 11 amt_reg_b[SHAMT_W-1:0]
- src_data  in  DATA_W  value to shift
- instr  in  DATA_W  instruction word
- amt_reg_a  in  DATA_W  register operand A
- amt_reg_b  in  DATA_W  register operand B
- busy  out  1  high in SHIFT state
- done  out  1  one-cycle pulse, result valid
- result  out  DATA_W  shifted value register

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE, result=0, busy=0, done=0, remaining=0, op register=00. Reset applies from any state; an in-flight shift is abandoned and no done pulse is generated.
- States are IDLE, SHIFT, DONE; 2-bit encoding.
- IDLE/DONE, start=1: capture src_data into result, op, and the selected amount into rem.
  - If amt==0: go to DONE.
  - Otherwise: go to SHIFT.
  - Only the low SHAMT_W bits of register sources are used; upper bits are ignored.
- IDLE/DONE, start=0:
  - DONE→IDLE.
  - IDLE stays IDLE.
- SHIFT, each edge:
  - k = min(rem, STEP); result shifted by k per op; rem = rem−k.
  - If the new rem==0: go to DONE.
  - start is ignored.
- Shift semantics:
  - SLL fills zeros.
  - SRL fills zeros.
  - SRA replicates result[DATA_W−1] as of the current cycle.
  - ROR rotates right.
- Latency: the start edge plus ceil(amt/STEP) SHIFT edges; done is high in the cycle after the last edge. amt=0 gives done one cycle after start.
- done is high only in DONE, exactly one cycle. busy is high only in SHIFT.
- result changes during SHIFT and is stable from DONE until the next accepted start.
- Back-to-back: start asserted while in DONE is accepted (same rules as IDLE); done still pulses for one cycle.
- Max amount DATA_W−1 takes ceil((DATA_W−1)/STEP) SHIFT cycles (31/4 → 8).

Optional Feature:
- Macro SHIFT_UNIT_ROTATE_EN.
- Defined: op=11 performs rotate-right by the amount, multi-cycle as above.
- Undefined: op=11 is a no-op. result=src_data, state goes straight to DONE regardless of amount, done one cycle after start; rotate logic is not synthesised.

Decomposition:
- Shared package shift_pkg holds:
  - op encodings: SH_SLL, SH_SRL, SH_SRA, SH_ROR
  - amt_sel encodings: AMT_INSTR, AMT_CONST, AMT_REG_A, AMT_REG_B
  - the state enum
- One natural sub-module: shift_amt_sel, the combinational 4:1 amount selector (parametrised DATA_W/SHAMT_W/SHAMT_LSB/CONST_AMT), instantiated once.
- The step shifter stays inline.

Test Plan:
1. Reset held low 3 cycles mid-SHIFT (SLL by 20) → busy=0, done=0, result=0, no done pulse after release.
2. op=SLL, amt_sel=00, instr[10:6]=5, src=0x0000_0001 → done after 1+2 cycles, result=0x0000_0020.
3. op=SRA, amt_sel=10, amt_reg_a=0xFFFF_FFFF (amt 31), src=0x8000_0000 → 8 busy cycles, result=0xFFFF_FFFF.
4. op=SRL, amt_sel=01, src=0xABCD_1234 → result=0x0000_ABCD after 4 SHIFT cycles; start pulsed while busy is ignored.
5. amt_sel=11, amt_reg_b=0x20 (low bits 0) → done one cycle after start, result=src_data unchanged.
6. op=11, src=0x0000_00F1, amt 4: with macro → 0x1000_000F after 1 SHIFT cycle; without → 0x0000_00F1, done one cycle after start.
